// File: rtl/ycr1_dmem_sram_tgt_pkg.sv
// ycr1_dmem_sram_tgt_pkg
//  Shared dmem interface encodings (command, width, response) and the state
//  type of the SRAM target FSM, plus the alignment check used at accept.
package ycr1_dmem_sram_tgt_pkg;

  typedef enum logic {
    YCR1_MEM_CMD_RD = 1'b0,
    YCR1_MEM_CMD_WR = 1'b1
  } type_ycr1_mem_cmd_e;

  typedef enum logic [1:0] {
    YCR1_MEM_WIDTH_BYTE  = 2'b00,
    YCR1_MEM_WIDTH_HWORD = 2'b01,
    YCR1_MEM_WIDTH_WORD  = 2'b10,
    YCR1_MEM_WIDTH_RSVD  = 2'b11
  } type_ycr1_mem_width_e;

  typedef enum logic [1:0] {
    YCR1_MEM_RESP_NOTRDY = 2'b00,
    YCR1_MEM_RESP_RDY_OK = 2'b01,
    YCR1_MEM_RESP_RDY_ER = 2'b10
  } type_ycr1_mem_resp_e;

  typedef enum logic [1:0] {
    TGT_IDLE,
    TGT_ACCESS,
    TGT_WAIT,
    TGT_RESP
  } type_ycr1_dmem_tgt_fsm_e;

  // True when the width is reserved or the byte offset breaks natural alignment.
  function automatic logic mem_misaligned(input type_ycr1_mem_width_e width,
                                          input logic [1:0] offset);
    logic bad;
    case (width)
      YCR1_MEM_WIDTH_BYTE:  bad = 1'b0;
      YCR1_MEM_WIDTH_HWORD: bad = offset[0];
      YCR1_MEM_WIDTH_WORD:  bad = |offset;
      default:              bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ycr1_dmem_sram_tgt_if.sv
// ycr1_dmem_sram_tgt_if
//  Core dmem request/response bundle.
//  master : core side (drives req/cmd/width/addr/wdata, receives ack/rdata/resp)
//  slave  : target side (the SRAM target)
interface ycr1_dmem_sram_tgt_if;
  import ycr1_dmem_sram_tgt_pkg::*;

  logic                 dmem_req;
  type_ycr1_mem_cmd_e   dmem_cmd;
  type_ycr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr;
  logic [31:0]          dmem_wdata;
  logic                 dmem_req_ack;
  logic [31:0]          dmem_rdata;
  type_ycr1_mem_resp_e  dmem_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/ycr1_dmem_sram_tgt_lane_steer.sv
// ycr1_dmem_lane_steer
//  Combinational byte-lane logic for a 32-bit little-endian data port.
//  width, offset : access width and byte offset (addr[1:0])
//  wdata_in      : right-justified write data
//  rdata_word    : full 32-bit word read from memory
//  be            : byte enables for the access
//  wdata_lane    : write data replicated across all lanes
//  rdata_out     : read data extracted and zero-extended, right-justified
module ycr1_dmem_lane_steer
  import ycr1_dmem_sram_tgt_pkg::*;
(
  input  type_ycr1_mem_width_e width,
  input  logic [1:0]           offset,
  input  logic [31:0]          wdata_in,
  input  logic [31:0]          rdata_word,
  output logic [3:0]           be,
  output logic [31:0]          wdata_lane,
  output logic [31:0]          rdata_out
);

  logic [31:0] rd_shift;

  always_comb begin
    rd_shift = rdata_word >> {offset, 3'b000};
    case (width)
      YCR1_MEM_WIDTH_BYTE: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata_in[7:0]}};
        rdata_out  = {24'h0, rd_shift[7:0]};
      end
      YCR1_MEM_WIDTH_HWORD: begin
        be         = 4'b0011 << offset;
        wdata_lane = {2{wdata_in[15:0]}};
        rdata_out  = {16'h0, (offset[1] ? rdata_word[31:16] : rdata_word[15:0])};
      end
      YCR1_MEM_WIDTH_WORD: begin
        be         = 4'b1111;
        wdata_lane = wdata_in;
        rdata_out  = rdata_word;
      end
      default: begin
        be         = '0;
        wdata_lane = '0;
        rdata_out  = '0;
      end
    endcase
  end

endmodule

// File: rtl/ycr1_dmem_sram_tgt.sv
// ycr1_dmem_sram_tgt
//  dmem target servicing one request at a time from a single-port synchronous
//  SRAM (data TCM). Checks width/alignment/window, steers byte lanes and
//  answers RDY_OK / RDY_ER.
//  core_clk, core_rst_n : clock, async active-low reset
//  dmem                 : dmem request/response bundle (slave side)
//  sram_cs_o/we_o       : SRAM select / write enable, one cycle per access
//  sram_addr_o          : SRAM word address (dmem_addr[AW+1:2])
//  sram_be_o            : byte enables
//  sram_wdata_o         : lane-steered write data
//  sram_rdata_i         : read data, valid 1+WAIT_STATES cycles after the cs cycle
module ycr1_dmem_sram_tgt
  import ycr1_dmem_sram_tgt_pkg::*;
#(
  parameter int unsigned AW          = 9,
  parameter logic [31:0] BASE_ADDR   = 32'h0C00_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 core_clk,
  input  logic                 core_rst_n,
  ycr1_dmem_sram_tgt_if.slave  dmem,
  output logic                 sram_cs_o,
  output logic                 sram_we_o,
  output logic [AW-1:0]        sram_addr_o,
  output logic [3:0]           sram_be_o,
  output logic [31:0]          sram_wdata_o,
  input  logic [31:0]          sram_rdata_i
);

  localparam int unsigned WIN_LSB = AW + 2;

  type_ycr1_dmem_tgt_fsm_e state, state_next;
  logic [2:0]              cnt, cnt_next;

  type_ycr1_mem_width_e    req_width;
  logic [1:0]              req_off;
  type_ycr1_mem_cmd_e      req_cmd;

  logic                    accept;
  logic                    win_hit;
  logic                    req_err;

  type_ycr1_mem_width_e    steer_width;
  logic [1:0]              steer_off;
  logic [3:0]              steer_be;
  logic [31:0]             steer_wdata;
  logic [31:0]             steer_rdata;

  logic                    cs_next;
  logic                    we_next;
  logic [AW-1:0]           addr_next;
  logic [3:0]              be_next;
  logic [31:0]             wdata_next;
  type_ycr1_mem_resp_e     resp_next;
  logic [31:0]             rdata_next;

  assign dmem.dmem_req_ack = (state == TGT_IDLE) || (state == TGT_RESP);
  assign accept            = dmem.dmem_req & dmem.dmem_req_ack;

  assign win_hit = (dmem.dmem_addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign req_err = mem_misaligned(dmem.dmem_width, dmem.dmem_addr[1:0]) | ~win_hit;

  // One steering instance serves both directions: write lanes are only needed
  // at accept (IDLE/RESP, live request), read extraction only at the WAIT
  // capture (registered request), so the two uses never overlap.
  assign steer_width = (state == TGT_WAIT) ? req_width : dmem.dmem_width;
  assign steer_off   = (state == TGT_WAIT) ? req_off   : dmem.dmem_addr[1:0];

  ycr1_dmem_lane_steer u_lane_steer (
    .width      (steer_width),
    .offset     (steer_off),
    .wdata_in   (dmem.dmem_wdata),
    .rdata_word (sram_rdata_i),
    .be         (steer_be),
    .wdata_lane (steer_wdata),
    .rdata_out  (steer_rdata)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cs_next    = 1'b0;
    we_next    = 1'b0;
    addr_next  = '0;
    be_next    = '0;
    wdata_next = '0;
    resp_next  = YCR1_MEM_RESP_NOTRDY;
    rdata_next = '0;

    case (state)
      TGT_IDLE, TGT_RESP: begin
        if (accept) begin
          if (req_err) begin
            state_next = TGT_RESP;
            resp_next  = YCR1_MEM_RESP_RDY_ER;
          end else begin
            state_next = TGT_ACCESS;
            cs_next    = 1'b1;
            we_next    = (dmem.dmem_cmd == YCR1_MEM_CMD_WR);
            addr_next  = dmem.dmem_addr[AW+1:2];
            be_next    = steer_be;
            wdata_next = steer_wdata;
          end
        end else begin
          state_next = TGT_IDLE;
        end
      end
      TGT_ACCESS: begin
        state_next = TGT_WAIT;
        cnt_next   = 3'(WAIT_STATES);
      end
      TGT_WAIT: begin
        if (cnt == 3'd0) begin
          state_next = TGT_RESP;
          resp_next  = YCR1_MEM_RESP_RDY_OK;
          if (req_cmd == YCR1_MEM_CMD_RD) begin
            rdata_next = steer_rdata;
          end
        end else begin
          cnt_next = cnt - 3'd1;
        end
      end
      default: state_next = TGT_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state           <= TGT_IDLE;
      cnt             <= '0;
      req_width       <= YCR1_MEM_WIDTH_BYTE;
      req_off         <= '0;
      req_cmd         <= YCR1_MEM_CMD_RD;
      sram_cs_o       <= 1'b0;
      sram_we_o       <= 1'b0;
      sram_addr_o     <= '0;
      sram_be_o       <= '0;
      sram_wdata_o    <= '0;
      dmem.dmem_resp  <= YCR1_MEM_RESP_NOTRDY;
      dmem.dmem_rdata <= '0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      sram_cs_o       <= cs_next;
      sram_we_o       <= we_next;
      sram_addr_o     <= addr_next;
      sram_be_o       <= be_next;
      sram_wdata_o    <= wdata_next;
      dmem.dmem_resp  <= resp_next;
      dmem.dmem_rdata <= rdata_next;
      if (accept) begin
        req_width <= dmem.dmem_width;
        req_off   <= dmem.dmem_addr[1:0];
        req_cmd   <= dmem.dmem_cmd;
      end
    end
  end

endmodule

// File: tb/tb_ycr1_dmem_sram_tgt.sv
module tb_ycr1_dmem_sram_tgt;
  import ycr1_dmem_sram_tgt_pkg::*;

  localparam int unsigned AW = 9;

  logic core_clk = 1'b0;
  logic core_rst_n = 1'b0;
  always #5 core_clk = ~core_clk;

  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    else n_pass++;
  endtask

  // DUT 0: no wait states
  ycr1_dmem_sram_tgt_if if0 ();
  logic          cs0, we0;
  logic [AW-1:0] addr0;
  logic [3:0]    be0;
  logic [31:0]   wd0, rd0;
  logic [31:0]   mem0 [2**AW];

  ycr1_dmem_sram_tgt #(.AW(AW), .BASE_ADDR(32'h0C00_0000), .WAIT_STATES(0)) dut0 (
    .core_clk(core_clk), .core_rst_n(core_rst_n), .dmem(if0),
    .sram_cs_o(cs0), .sram_we_o(we0), .sram_addr_o(addr0), .sram_be_o(be0),
    .sram_wdata_o(wd0), .sram_rdata_i(rd0)
  );

  always @(posedge core_clk) begin
    if (cs0) begin
      if (we0) begin
        for (int b = 0; b < 4; b++)
          if (be0[b]) mem0[addr0][8*b +: 8] <= wd0[8*b +: 8];
      end
      rd0 <= mem0[addr0];
    end
  end

  // DUT 2: two wait states
  ycr1_dmem_sram_tgt_if if2 ();
  logic          cs2, we2;
  logic [AW-1:0] addr2;
  logic [3:0]    be2;
  logic [31:0]   wd2, p0, p1, p2;
  logic [31:0]   mem2 [2**AW];

  ycr1_dmem_sram_tgt #(.AW(AW), .BASE_ADDR(32'h0C00_0000), .WAIT_STATES(2)) dut2 (
    .core_clk(core_clk), .core_rst_n(core_rst_n), .dmem(if2),
    .sram_cs_o(cs2), .sram_we_o(we2), .sram_addr_o(addr2), .sram_be_o(be2),
    .sram_wdata_o(wd2), .sram_rdata_i(p2)
  );

  always @(posedge core_clk) begin
    if (cs2 && !we2) p0 <= mem2[addr2];
    p1 <= p0;
    p2 <= p1;
  end

  // Scoreboard for DUT 0
  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t sb[$];
  int cs_cnt = 0;
  int exp_cs = 0;

  always @(negedge core_clk) begin
    exp_t e;
    if (core_rst_n && cs0) cs_cnt++;
    if (core_rst_n && if0.dmem_resp != YCR1_MEM_RESP_NOTRDY) begin
      if (sb.size() == 0) begin
        chk("stray_resp", if0.dmem_resp, YCR1_MEM_RESP_NOTRDY);
      end else begin
        e = sb.pop_front();
        chk("sb_resp", if0.dmem_resp, e.resp);
        chk("sb_rdata", if0.dmem_rdata, e.rdata);
        chk("sb_latency", cyc, e.due);
      end
    end
  end

  // Issue one request on DUT 0; exp_data is the steered SRAM write data for
  // writes and the returned read data for reads.
  task automatic req0(input type_ycr1_mem_cmd_e cmd, input type_ycr1_mem_width_e w,
                      input logic [31:0] a, input logic [31:0] wd, input bit ok,
                      input logic [3:0] exp_be, input logic [31:0] exp_data);
    exp_t e;
    bit   got;
    int   k;
    @(negedge core_clk);
    if0.dmem_cmd   = cmd;
    if0.dmem_width = w;
    if0.dmem_addr  = a;
    if0.dmem_wdata = wd;
    if0.dmem_req   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if0.dmem_req_ack) begin
        got = 1'b1;
        break;
      end
      @(negedge core_clk);
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      if0.dmem_req = 1'b0;
      return;
    end
    k = cyc;
    e.resp  = ok ? YCR1_MEM_RESP_RDY_OK : YCR1_MEM_RESP_RDY_ER;
    e.rdata = (ok && cmd == YCR1_MEM_CMD_RD) ? exp_data : 32'h0;
    e.due   = k + (ok ? 3 : 1);
    sb.push_back(e);
    if (ok) exp_cs++;
    @(posedge core_clk);
    #1;
    // Garble the bus after the accept edge: the access must use captured fields.
    if0.dmem_req   = 1'b0;
    if0.dmem_addr  = $urandom;
    if0.dmem_wdata = $urandom;
    if0.dmem_width = type_ycr1_mem_width_e'($urandom_range(0, 3));
    if0.dmem_cmd   = type_ycr1_mem_cmd_e'(~cmd);
    @(negedge core_clk);
    chk("t1_cs", cs0, ok);
    if (ok) begin
      chk("t1_we", we0, cmd == YCR1_MEM_CMD_WR);
      chk("t1_addr", addr0, a[AW+1:2]);
      chk("t1_be", be0, exp_be);
      if (cmd == YCR1_MEM_CMD_WR) chk("t1_wdata", wd0, exp_data);
    end
  endtask

  localparam type_ycr1_mem_cmd_e   RD = YCR1_MEM_CMD_RD;
  localparam type_ycr1_mem_cmd_e   WR = YCR1_MEM_CMD_WR;
  localparam type_ycr1_mem_width_e B  = YCR1_MEM_WIDTH_BYTE;
  localparam type_ycr1_mem_width_e H  = YCR1_MEM_WIDTH_HWORD;
  localparam type_ycr1_mem_width_e W  = YCR1_MEM_WIDTH_WORD;
  localparam type_ycr1_mem_width_e X  = YCR1_MEM_WIDTH_RSVD;

  initial begin
    if0.dmem_req = 1'b0; if0.dmem_cmd = RD; if0.dmem_width = W;
    if0.dmem_addr = '0;  if0.dmem_wdata = '0;
    if2.dmem_req = 1'b0; if2.dmem_cmd = RD; if2.dmem_width = W;
    if2.dmem_addr = '0;  if2.dmem_wdata = '0;
    mem2[7] = 32'hCAFE_F00D;

    repeat (3) @(negedge core_clk);
    chk("rst_resp", if0.dmem_resp, YCR1_MEM_RESP_NOTRDY);
    chk("rst_rdata", if0.dmem_rdata, 32'h0);
    chk("rst_cs", cs0, 1'b0);
    chk("rst_ack_idle", if0.dmem_req_ack, 1'b1);
    core_rst_n = 1'b1;
    repeat (2) @(negedge core_clk);

    // word write, then lane-steered reads
    req0(WR, W, 32'h0C00_0010, 32'hDEAD_BEEF, 1, 4'hF, 32'hDEAD_BEEF);
    req0(RD, W, 32'h0C00_0010, 32'h0,         1, 4'hF, 32'hDEAD_BEEF);
    req0(WR, W, 32'h0C00_0010, 32'h1122_3344, 1, 4'hF, 32'h1122_3344);
    req0(RD, B, 32'h0C00_0013, 32'h0,         1, 4'h8, 32'h0000_0011);
    req0(RD, H, 32'h0C00_0012, 32'h0,         1, 4'hC, 32'h0000_1122);
    req0(RD, B, 32'h0C00_0010, 32'h0,         1, 4'h1, 32'h0000_0044);
    req0(RD, H, 32'h0C00_0010, 32'h0,         1, 4'h3, 32'h0000_3344);
    // sub-word writes replicate data across lanes
    req0(WR, B, 32'h0C00_0011, 32'h0000_00AB, 1, 4'h2, 32'hABAB_ABAB);
    req0(WR, H, 32'h0C00_0012, 32'h0000_5566, 1, 4'hC, 32'h5566_5566);
    req0(RD, W, 32'h0C00_0010, 32'h0,         1, 4'hF, 32'h5566_AB44);
    req0(RD, B, 32'h0C00_0011, 32'h0,         1, 4'h2, 32'h0000_00AB);
    // errors: misalignment, reserved width, window misses
    req0(WR, H, 32'h0C00_0001, 32'h1234,      0, 4'h0, 32'h0);
    req0(WR, W, 32'h0D00_0000, 32'h1234,      0, 4'h0, 32'h0);
    req0(RD, W, 32'h0C00_0002, 32'h0,         0, 4'h0, 32'h0);
    req0(RD, X, 32'h0C00_0010, 32'h0,         0, 4'h0, 32'h0);
    req0(RD, W, 32'h0C00_0800, 32'h0,         0, 4'h0, 32'h0);
    // top word of the window
    req0(WR, W, 32'h0C00_07FC, 32'hA5A5_0001, 1, 4'hF, 32'hA5A5_0001);
    req0(RD, W, 32'h0C00_07FC, 32'h0,         1, 4'hF, 32'hA5A5_0001);
    // back-to-back, including error after ok and ok after error
    req0(RD, W, 32'h0C00_0010, 32'h0,         1, 4'hF, 32'h5566_AB44);
    req0(RD, H, 32'h0C00_07FE, 32'h0,         1, 4'hC, 32'h0000_A5A5);
    req0(RD, H, 32'h0C00_0003, 32'h0,         0, 4'h0, 32'h0);
    req0(RD, B, 32'h0C00_07FC, 32'h0,         1, 4'h1, 32'h0000_0001);

    // reset during WAIT abandons the access
    req0(RD, W, 32'h0C00_0010, 32'h0,         1, 4'hF, 32'h5566_AB44);
    @(negedge core_clk);
    core_rst_n = 1'b0;
    #1;
    chk("midrst_cs", cs0, 1'b0);
    chk("midrst_resp", if0.dmem_resp, YCR1_MEM_RESP_NOTRDY);
    chk("midrst_ack", if0.dmem_req_ack, 1'b1);
    sb.delete();
    @(negedge core_clk);
    core_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge core_clk);
      chk("post_rst_quiet", if0.dmem_resp, YCR1_MEM_RESP_NOTRDY);
    end
    req0(RD, W, 32'h0C00_07FC, 32'h0,         1, 4'hF, 32'hA5A5_0001);

    // two wait states on DUT 2
    @(negedge core_clk);
    if2.dmem_cmd = RD; if2.dmem_width = W; if2.dmem_addr = 32'h0C00_001C;
    if2.dmem_req = 1'b1;
    chk("ws2_ack_idle", if2.dmem_req_ack, 1'b1);
    @(posedge core_clk);
    #1;
    if2.dmem_req = 1'b0;
    if2.dmem_addr = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge core_clk);
      if (i == 1) chk("ws2_cs", cs2, 1'b1);
      chk("ws2_ack_busy", if2.dmem_req_ack, 1'b0);
      chk("ws2_notrdy", if2.dmem_resp, YCR1_MEM_RESP_NOTRDY);
    end
    @(negedge core_clk);
    chk("ws2_resp", if2.dmem_resp, YCR1_MEM_RESP_RDY_OK);
    chk("ws2_rdata", if2.dmem_rdata, 32'hCAFE_F00D);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge core_clk);
    repeat (3) @(negedge core_clk);
    chk("sb_drain", sb.size(), 0);
    chk("cs_count", cs_cnt, exp_cs);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
